// File: rtl/calc_entry_sequencer.sv
// Keypad-to-ALU sequencer: builds hex operands, issues one req/ack op.
// Optional macro CALC_SEQ_CHAIN_EN: operator key in SHOW chains result.
module calc_entry_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              ClearAll,
  input  logic              ClearEntry,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_sub,
  output logic              alu_req,
  input  logic              alu_ack,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ovf,
  output logic [DATA_W-1:0] display,
  output logic              ovf_flag,
  output logic [1:0]        state_dbg
);

  localparam int NDIG = DATA_W / 4;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    EXEC    = 2'd2,
    SHOW    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] entry_q, entry_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              sub_q, sub_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] fresh;
  logic              is_dig;
  logic              is_op;
  logic              is_eq;

  // MS digit falls off the top; nothing wraps into the LS nibble
  generate
    if (NDIG > 1) begin : g_shift
      assign shifted = {entry_q[DATA_W-5:0], key_code};
    end else begin : g_single
      assign shifted = key_code;
    end
  endgenerate

  assign fresh  = DATA_W'(key_code);
  assign is_dig = key_code <= 4'h9;
  assign is_op  = key_code[3:1] == 3'b101;
  assign is_eq  = key_code == 4'hF;

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    sub_d    = sub_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      ENTER_A: begin
        if (!ClearEntry) begin
          entry_d = '0;
        end else if (key_valid) begin
          unique case (1'b1)
            is_dig: entry_d = shifted;
            is_op: begin
              a_d     = entry_q;
              sub_d   = key_code[0];
              entry_d = '0;
              state_d = ENTER_B;
            end
            default: ;
          endcase
        end
      end
      ENTER_B: begin
        if (!ClearEntry) begin
          entry_d = '0;
        end else if (key_valid) begin
          unique case (1'b1)
            is_dig: entry_d = shifted;
            is_op:  sub_d   = key_code[0];
            is_eq: begin
              b_d     = entry_q;
              state_d = EXEC;
            end
            default: ;
          endcase
        end
      end
      EXEC: begin
        if (alu_ack) begin
          result_d = alu_result;
          ovf_d    = alu_ovf;
          state_d  = SHOW;
        end
      end
      SHOW: begin
        if (!ClearEntry) begin
          entry_d = '0;
          ovf_d   = 1'b0;
          state_d = ENTER_A;
        end else if (key_valid) begin
          unique case (1'b1)
            is_dig: begin
              entry_d = fresh;
              ovf_d   = 1'b0;
              state_d = ENTER_A;
            end
`ifdef CALC_SEQ_CHAIN_EN
            is_op: begin
              a_d     = result_q;
              sub_d   = key_code[0];
              entry_d = '0;
              ovf_d   = 1'b0;
              state_d = ENTER_B;
            end
`endif
            default: ;
          endcase
        end
      end
      default: state_d = ENTER_A;
    endcase
  end

  always_ff @(posedge clock or negedge ClearAll) begin
    if (!ClearAll) begin
      state_q  <= ENTER_A;
      entry_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      sub_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      sub_q    <= sub_d;
      ovf_q    <= ovf_d;
    end
  end

  // Decoded from state so reset drops the request without a clock
  assign alu_req   = state_q == EXEC;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sub   = sub_q;
  assign display   = (state_q == SHOW) ? result_q : entry_q;
  assign ovf_flag  = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Scoreboard bench for calc_entry_sequencer.
// Honours CALC_SEQ_CHAIN_EN for the SHOW operator-key case.
module tb_calc_entry_sequencer;

  logic       clock = 1'b0;
  logic       ClearAll = 1'b0;
  logic       ClearEntry = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [7:0] alu_a, alu_b, display, alu_result = 8'h0;
  logic       alu_sub, alu_req, ovf_flag;
  logic       alu_ack = 1'b0;
  logic       alu_ovf = 1'b0;
  logic [1:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    int         len;
  } exp_t;

  exp_t q[$];
  int   req_cnt = 0;

  calc_entry_sequencer #(.DATA_W(8)) dut (
    .clock      (clock),
    .ClearAll   (ClearAll),
    .ClearEntry (ClearEntry),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sub    (alu_sub),
    .alu_req    (alu_req),
    .alu_ack    (alu_ack),
    .alu_result (alu_result),
    .alu_ovf    (alu_ovf),
    .display    (display),
    .ovf_flag   (ovf_flag),
    .state_dbg  (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops an expected transaction whenever the DUT sees req&ack
  always @(negedge clock) begin
    if (alu_req) begin
      req_cnt++;
      if (alu_ack) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack expected none");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("txn_a", 32'(alu_a), 32'(e.a));
          chk("txn_b", 32'(alu_b), 32'(e.b));
          chk("txn_sub", 32'(alu_sub), 32'(e.sub));
          chk("txn_req_len", req_cnt, e.len);
        end
      end
    end else begin
      req_cnt = 0;
    end
  end

  task automatic key(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clock); #1;
    key_valid = 1'b0;
  endtask

  task automatic clr();
    ClearEntry = 1'b0;
    @(posedge clock); #1;
    ClearEntry = 1'b1;
  endtask

  task automatic do_exec(input int dly, input logic [7:0] res,
                         input logic ov, input logic [7:0] ea,
                         input logic [7:0] eb, input logic es);
    exp_t e;
    chk("req_up", 32'(alu_req), 32'd1);
    chk("exec_state", 32'(state_dbg), 32'd2);
    e.a = ea; e.b = eb; e.sub = es; e.len = dly + 1;
    q.push_back(e);
    repeat (dly) begin
      @(posedge clock); #1;
    end
    alu_ack    = 1'b1;
    alu_result = res;
    alu_ovf    = ov;
    @(posedge clock); #1;
    alu_ack = 1'b0;
    alu_ovf = 1'b0;
    chk("req_down", 32'(alu_req), 32'd0);
    chk("show_state", 32'(state_dbg), 32'd3);
    chk("show_disp", 32'(display), 32'(res));
    chk("show_ovf", 32'(ovf_flag), 32'(ov));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_req", 32'(alu_req), 32'd0);
    chk("rst_out", {alu_a, alu_b, display, 5'd0, alu_sub, ovf_flag, 1'b0}, 32'd0);
    ClearAll = 1'b1;
    @(posedge clock); #1;

    // 12 A 05 F, ack 3 cycles after req
    key(4'h1); chk("d1", 32'(display), 32'h01);
    key(4'h2); chk("d12", 32'(display), 32'h12);
    key(4'hA);
    chk("opA_state", 32'(state_dbg), 32'd1);
    chk("opA_a", 32'(alu_a), 32'h12);
    chk("opA_disp", 32'(display), 32'h00);
    key(4'h0); key(4'h5);
    chk("d05", 32'(display), 32'h05);
    key(4'hF);
    do_exec(3, 8'h17, 1'b0, 8'h12, 8'h05, 1'b0);

    // digit leaves SHOW, MS digit drops off
    key(4'h3);
    chk("s3_state", 32'(state_dbg), 32'd0);
    chk("d03", 32'(display), 32'h03);
    key(4'h4); chk("d34", 32'(display), 32'h34);
    key(4'h5); chk("d45", 32'(display), 32'h45);

    // last operator wins; C/E ignored
    clr(); chk("clrA", 32'(display), 32'h00);
    key(4'h9); key(4'hB);
    chk("opB_sub", 32'(alu_sub), 32'd1);
    chk("opB_a", 32'(alu_a), 32'h09);
    key(4'hC);
    chk("keyC_state", 32'(state_dbg), 32'd1);
    key(4'hA); chk("opA2_sub", 32'(alu_sub), 32'd0);
    key(4'h1); key(4'hE);
    chk("keyE_disp", 32'(display), 32'h01);
    key(4'hF);
    do_exec(0, 8'h0A, 1'b1, 8'h09, 8'h01, 1'b0);

    // digit from SHOW clears ovf
    key(4'h7);
    chk("ovf_clr", 32'(ovf_flag), 32'd0);
    chk("d07", 32'(display), 32'h07);
    key(4'hA);
    ClearEntry = 1'b0;
    key(4'h3);
    ClearEntry = 1'b1;
    chk("ce_key_disp", 32'(display), 32'h00);
    chk("ce_key_state", 32'(state_dbg), 32'd1);
    key(4'h2);
    key(4'hF);
    do_exec(1, 8'h20, 1'b0, 8'h07, 8'h02, 1'b0);

    key(4'hB);
`ifdef CALC_SEQ_CHAIN_EN
    chk("chain_state", 32'(state_dbg), 32'd1);
    chk("chain_a", 32'(alu_a), 32'h20);
    chk("chain_sub", 32'(alu_sub), 32'd1);
    key(4'h0); key(4'h8); key(4'hF);
    do_exec(0, 8'h18, 1'b0, 8'h20, 8'h08, 1'b1);
`else
    chk("nochain_state", 32'(state_dbg), 32'd3);
    chk("nochain_disp", 32'(display), 32'h20);
    chk("nochain_a", 32'(alu_a), 32'h07);
`endif

    clr();
    chk("ce_show_state", 32'(state_dbg), 32'd0);
    chk("ce_show_disp", 32'(display), 32'h00);

    // keys and ClearEntry dropped in EXEC, then async ClearAll
    key(4'h1); key(4'hA); key(4'h2); key(4'hF);
    chk("exec_req", 32'(alu_req), 32'd1);
    key(4'h5);
    chk("exec_key_disp", 32'(display), 32'h02);
    clr();
    chk("exec_ce_disp", 32'(display), 32'h02);
    chk("exec_ce_state", 32'(state_dbg), 32'd2);
    #1 ClearAll = 1'b0;
    #1;
    chk("ca_req", 32'(alu_req), 32'd0);
    chk("ca_state", 32'(state_dbg), 32'd0);
    chk("ca_out", {alu_a, alu_b, display, 5'd0, alu_sub, ovf_flag, 1'b0}, 32'd0);
    #1 ClearAll = 1'b1;
    @(posedge clock); #1;
    alu_ack    = 1'b1;
    alu_result = 8'h55;
    @(posedge clock); #1;
    alu_ack = 1'b0;
    chk("late_ack_state", 32'(state_dbg), 32'd0);
    chk("late_ack_disp", 32'(display), 32'h00);

    repeat (2) @(posedge clock);
    chk("sb_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
